// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, ALUOp encodings and control-bundle widths.
package mips_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_BEQ   = 6'h04,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam int unsigned WB_W = 2;
    localparam int unsigned M_W  = 3;
    localparam int unsigned EX_W = 4;

endpackage

// File: rtl/i_decode_if.sv
// Register-file bus between the decode stage (master) and the register file (slave).
interface i_decode_if #(
    parameter int unsigned DW = 32
);
    logic          we;
    logic [4:0]    waddr;
    logic [DW-1:0] wdata;
    logic [4:0]    raddr1;
    logic [4:0]    raddr2;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;

    modport master (output we, waddr, wdata, raddr1, raddr2, input rdata1, rdata2);
    modport slave  (input we, waddr, wdata, raddr1, raddr2, output rdata1, rdata2);
endinterface

// File: rtl/i_decode_reg_file.sv
// 32-entry register file: two async read ports, one sync write port, $0 hardwired to zero.
// Optional macro ID_WB_BYPASS_EN forwards a same-cycle write onto the read ports.
module reg_file
    import mips_pkg::*;
#(
    parameter int unsigned NREG = 32,
    parameter int unsigned DW   = 32
)(
    input logic       clk,
    input logic       rst,
    i_decode_if.slave rf
);

    logic [DW-1:0] regs_q [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else if (rf.we && rf.waddr != '0) begin
            regs_q[rf.waddr] <= rf.wdata;
        end
    end

    always_comb begin
        rf.rdata1 = (rf.raddr1 == '0) ? '0 : regs_q[rf.raddr1];
        rf.rdata2 = (rf.raddr2 == '0) ? '0 : regs_q[rf.raddr2];
`ifdef ID_WB_BYPASS_EN
        // Write-before-read: the in-flight write-back value wins over the stored one.
        if (rf.we && rf.waddr != '0 && rf.waddr == rf.raddr1) rf.rdata1 = rf.wdata;
        if (rf.we && rf.waddr != '0 && rf.waddr == rf.raddr2) rf.rdata2 = rf.wdata;
`endif
    end

endmodule

// File: rtl/i_decode.sv
// MIPS instruction-decode stage: control decode, register read, sign extension and ID/EX register.
// Optional macro ID_WB_BYPASS_EN (in reg_file) enables write-back to read-port bypass.
module i_decode
    import mips_pkg::*;
#(
    parameter int unsigned NREG = 32,
    parameter int unsigned DW   = 32
)(
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     IF_ID_instr,
    input  logic [DW-1:0]   IF_ID_npc,
    input  logic            EX_MEM_PCSrc,
    input  logic            MEM_WB_RegWrite,
    input  logic [4:0]      MEM_WB_Writereg,
    input  logic [DW-1:0]   WB_mux5_writedata,
    output logic [WB_W-1:0] ID_EX_wb,
    output logic [M_W-1:0]  ID_EX_m,
    output logic [EX_W-1:0] ID_EX_ex,
    output logic [DW-1:0]   ID_EX_npc,
    output logic [DW-1:0]   ID_EX_readdat1,
    output logic [DW-1:0]   ID_EX_readdat2,
    output logic [DW-1:0]   ID_EX_sign_ext,
    output logic [4:0]      ID_EX_instr_2016,
    output logic [4:0]      ID_EX_instr_1511
);

    i_decode_if #(.DW(DW)) rf_bus ();

    assign rf_bus.we     = MEM_WB_RegWrite;
    assign rf_bus.waddr  = MEM_WB_Writereg;
    assign rf_bus.wdata  = WB_mux5_writedata;
    assign rf_bus.raddr1 = IF_ID_instr[25:21];
    assign rf_bus.raddr2 = IF_ID_instr[20:16];

    reg_file #(.NREG(NREG), .DW(DW)) u_reg_file (
        .clk (clk),
        .rst (rst),
        .rf  (rf_bus)
    );

    logic [WB_W-1:0] wb_d, wb_q;
    logic [M_W-1:0]  m_d,  m_q;
    logic [EX_W-1:0] ex_d, ex_q;
    logic [DW-1:0]   sign_ext_d;

    // Flush only kills control; data fields still load and are don't-care downstream.
    always_comb begin
        wb_d = '0;
        m_d  = '0;
        ex_d = '0;
        if (!EX_MEM_PCSrc) begin
            case (IF_ID_instr[31:26])
                OP_RTYPE: begin wb_d = 2'b10; m_d = 3'b000; ex_d = {1'b1, ALUOP_RTYPE, 1'b0}; end
                OP_LW:    begin wb_d = 2'b11; m_d = 3'b010; ex_d = {1'b0, ALUOP_MEM,   1'b1}; end
                OP_SW:    begin wb_d = 2'b00; m_d = 3'b001; ex_d = {1'b0, ALUOP_MEM,   1'b1}; end
                OP_BEQ:   begin wb_d = 2'b00; m_d = 3'b100; ex_d = {1'b0, ALUOP_BEQ,   1'b0}; end
                default:  begin wb_d = '0;    m_d = '0;     ex_d = '0;                       end
            endcase
        end
    end

    assign sign_ext_d = {{(DW-16){IF_ID_instr[15]}}, IF_ID_instr[15:0]};

    logic [DW-1:0] npc_q, rd1_q, rd2_q, se_q;
    logic [4:0]    rt_q, rd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q  <= '0;
            m_q   <= '0;
            ex_q  <= '0;
            npc_q <= '0;
            rd1_q <= '0;
            rd2_q <= '0;
            se_q  <= '0;
            rt_q  <= '0;
            rd_q  <= '0;
        end else begin
            wb_q  <= wb_d;
            m_q   <= m_d;
            ex_q  <= ex_d;
            npc_q <= IF_ID_npc;
            rd1_q <= rf_bus.rdata1;
            rd2_q <= rf_bus.rdata2;
            se_q  <= sign_ext_d;
            rt_q  <= IF_ID_instr[20:16];
            rd_q  <= IF_ID_instr[15:11];
        end
    end

    assign ID_EX_wb         = wb_q;
    assign ID_EX_m          = m_q;
    assign ID_EX_ex         = ex_q;
    assign ID_EX_npc        = npc_q;
    assign ID_EX_readdat1   = rd1_q;
    assign ID_EX_readdat2   = rd2_q;
    assign ID_EX_sign_ext   = se_q;
    assign ID_EX_instr_2016 = rt_q;
    assign ID_EX_instr_1511 = rd_q;

endmodule

// File: doc/i_decode.md
Name: i_decode

Overview:
- Instruction-decode stage of the 5-stage MIPS pipeline; the consumer end of the IF/ID interface driven by the fetch stage.
- Each cycle it takes IF_ID_instr and IF_ID_npc, reads two source registers, sign-extends the immediate and decodes control. It registers everything into the ID/EX pipeline register.
- Contains the 32x32 register file, written from the write-back stage.
- Takes EX_MEM_PCSrc, the same signal fetch uses to redirect the PC, to squash the wrong-path instruction.

Parameters:
- NREG, 32, register-file depth; must be 32 for 5-bit specifiers.
- DW, 32, datapath width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- IF_ID_instr  in  32  instruction from IF/ID register
- IF_ID_npc  in  32  PC+4 from IF/ID register
- EX_MEM_PCSrc  in  1  taken-branch flush request
- MEM_WB_RegWrite  in  1  write-back enable
- MEM_WB_Writereg  in  5  write-back destination register
- WB_mux5_writedata  in  32  write-back data
- ID_EX_wb  out  2  {RegWrite, MemtoReg}
- ID_EX_m  out  3  {Branch, MemRead, MemWrite}
- ID_EX_ex  out  4  {RegDst, ALUOp[1:0], ALUSrc}
- ID_EX_npc  out  32  registered npc
- ID_EX_readdat1  out  32  rs value
- ID_EX_readdat2  out  32  rt value
- ID_EX_sign_ext  out  32  sign-extended instr[15:0]
- ID_EX_instr_2016  out  5  rt field
- ID_EX_instr_1511  out  5  rd field

Behaviour:
- Reset (async, rst=1):
  - All ID_EX_* outputs go to 0.
  - All 32 registers clear to 0.
  - Release takes effect at the next rising edge.
- Latency: one cycle. Values present on IF_ID_* before edge N appear on ID_EX_* after edge N.
- Decode on opcode = instr[31:26], given as {wb | m | ex}:
  - R-type 0x00: 10 | 000 | 1_10_0
  - lw 0x23: 11 | 010 | 0_00_1
  - sw 0x2B: 00 | 001 | 0_00_1
  - beq 0x04: 00 | 100 | 0_01_0
  - Any other opcode: all control zero (bubble).
- Sign extension: sign_ext = {16{instr[15]}, instr[15:0]}.
- Register fields: rs = instr[25:21], rt = instr[20:16], rd = instr[15:11].
- Register file:
  - Reads are combinational on rs and rt.
  - Write occurs at the rising edge when MEM_WB_RegWrite=1 and MEM_WB_Writereg != 0.
  - Register $0 always reads 0; writes to it are discarded.
- Flush: if EX_MEM_PCSrc=1 at an edge, ID_EX_wb, ID_EX_m and ID_EX_ex load 0. Data fields load normally (don't-care).
- Simultaneous flush and register write: the write still commits, since it belongs to an older instruction.
- Instruction 0x00000000 (sll $0) decodes as R-type writing $0. This is harmless and requires no special case.

Optional Feature:
- Macro: ID_WB_BYPASS_EN
- Defined: when MEM_WB_RegWrite=1, MEM_WB_Writereg != 0 and it equals rs or rt, that read port returns WB_mux5_writedata in the same cycle (write-before-read).
- Undefined: the read returns the pre-write register value. The write is visible one cycle later.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ
  - ALUOp encodings
  - control-bundle widths WB_W=2, M_W=3, EX_W=4
- One sub-module, reg_file: 2 async read ports, 1 sync write port, async reset, $0 hardwiring. The bypass mux lives in reg_file under ID_WB_BYPASS_EN.
- Control decode and the ID/EX register stay in i_decode.

Test Plan:
- Reset: assert rst mid-cycle -> all ID_EX_* = 0 immediately; after release, registers 1..31 read 0.
- Write/read: write reg 5=0x0000_00AA via MEM_WB. Next cycle apply IF_ID_instr=0x00A62020 (add $4,$5,$6) -> after edge: ID_EX_readdat1=0xAA, ID_EX_wb=2'b10, ID_EX_ex=4'b1100, ID_EX_instr_1511=4.
- lw decode: IF_ID_instr=0x8C43FFFC, npc=0x10 -> ID_EX_sign_ext=0xFFFFFFFC, ID_EX_m=3'b010, ID_EX_wb=2'b11, ID_EX_ex=4'b0001, ID_EX_npc=0x10, ID_EX_instr_2016=3.
- $0 protection: write 0xDEAD to reg 0, then read rs=0 -> 0.
- Flush: beq 0x10220003 with EX_MEM_PCSrc=1 -> all control fields 0. A concurrent write of reg 7=0x55 is readable next cycle.
- Bypass: same-cycle write reg 2=0x1234 and read rs=2 -> readdat1=0x1234 with ID_WB_BYPASS_EN defined; old value without it.
